// File: rtl/alu_cmd_sequencer_if.sv
// Command, ALU and response bundle for alu_cmd_sequencer.
// `STATUS_FLAGS_EN adds the rsp_zero/rsp_neg status signals.
interface alu_cmd_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int REP_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_sel;
  logic             cmd_src;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic [REP_W-1:0] cmd_rep;
  logic [WIDTH-1:0] alu_in1;
  logic [WIDTH-1:0] alu_in2;
  logic [2:0]       alu_sel;
  logic [WIDTH-1:0] alu_out;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             busy;
  logic [WIDTH-1:0] acc;
`ifdef STATUS_FLAGS_EN
  logic             rsp_zero;
  logic             rsp_neg;
`endif

  // The sequencer is the master: it initiates ALU operations.
  modport master (
    input  cmd_valid, cmd_sel, cmd_src, cmd_a, cmd_b, cmd_rep, alu_out, rsp_ready,
`ifdef STATUS_FLAGS_EN
    output rsp_zero, rsp_neg,
`endif
    output cmd_ready, alu_in1, alu_in2, alu_sel, rsp_valid, rsp_data, busy, acc
  );

  modport slave (
    output cmd_valid, cmd_sel, cmd_src, cmd_a, cmd_b, cmd_rep, alu_out, rsp_ready,
`ifdef STATUS_FLAGS_EN
    input  rsp_zero, rsp_neg,
`endif
    input  cmd_ready, alu_in1, alu_in2, alu_sel, rsp_valid, rsp_data, busy, acc
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Drives an external combinational 8-bit ALU, iterating with feedback and holding an accumulator.
// `STATUS_FLAGS_EN adds registered rsp_zero/rsp_neg flags.
module alu_cmd_sequencer #(
  parameter int WIDTH = 8,
  parameter int REP_W = 4
) (
  input logic clk,
  input logic rst,
  alu_cmd_sequencer_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_in1, w_in1_nxt;
  logic [WIDTH-1:0] r_in2, w_in2_nxt;
  logic [2:0]       r_sel, w_sel_nxt;
  logic [REP_W-1:0] r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_rsp_data, w_rsp_data_nxt;
  logic [WIDTH-1:0] r_acc, w_acc_nxt;
  logic             r_rsp_valid, w_rsp_valid_nxt;
`ifdef STATUS_FLAGS_EN
  logic             r_rsp_zero, w_rsp_zero_nxt;
  logic             r_rsp_neg, w_rsp_neg_nxt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_in1       <= '0;
      r_in2       <= '0;
      r_sel       <= '0;
      r_cnt       <= '0;
      r_rsp_data  <= '0;
      r_acc       <= '0;
      r_rsp_valid <= 1'b0;
`ifdef STATUS_FLAGS_EN
      r_rsp_zero  <= 1'b0;
      r_rsp_neg   <= 1'b0;
`endif
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      r_state     <= w_state_nxt;
      r_in1       <= w_in1_nxt;
      r_in2       <= w_in2_nxt;
      r_sel       <= w_sel_nxt;
      r_cnt       <= w_cnt_nxt;
      r_rsp_data  <= w_rsp_data_nxt;
      r_acc       <= w_acc_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
`ifdef STATUS_FLAGS_EN
      r_rsp_zero  <= w_rsp_zero_nxt;
      r_rsp_neg   <= w_rsp_neg_nxt;
`endif
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a hold default first, so no latch can be inferred.
    w_state_nxt     = r_state;
    w_in1_nxt       = r_in1;
    w_in2_nxt       = r_in2;
    w_sel_nxt       = r_sel;
    w_cnt_nxt       = r_cnt;
    w_rsp_data_nxt  = r_rsp_data;
    w_acc_nxt       = r_acc;
    w_rsp_valid_nxt = r_rsp_valid;
`ifdef STATUS_FLAGS_EN
    w_rsp_zero_nxt  = r_rsp_zero;
    w_rsp_neg_nxt   = r_rsp_neg;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          w_in1_nxt   = bus.cmd_src ? r_acc : bus.cmd_a;
          w_in2_nxt   = bus.cmd_b;
          w_sel_nxt   = bus.cmd_sel;
          w_cnt_nxt   = bus.cmd_rep;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // Feed the result back as operand 1 until the repeat count is exhausted.
        if (r_cnt != '0) begin
          w_in1_nxt = bus.alu_out;
          w_cnt_nxt = r_cnt - REP_W'(1);
        end else begin
          w_rsp_data_nxt  = bus.alu_out;
          w_acc_nxt       = bus.alu_out;
          w_rsp_valid_nxt = 1'b1;
`ifdef STATUS_FLAGS_EN
          w_rsp_zero_nxt  = (bus.alu_out == '0);
          w_rsp_neg_nxt   = bus.alu_out[WIDTH-1];
`endif
          w_state_nxt     = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
          w_state_nxt     = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.cmd_ready = (r_state == S_IDLE) && !rst;
  assign bus.alu_in1   = r_in1;
  assign bus.alu_in2   = r_in2;
  assign bus.alu_sel   = r_sel;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.acc       = r_acc;
`ifdef STATUS_FLAGS_EN
  assign bus.rsp_zero  = r_rsp_zero;
  assign bus.rsp_neg   = r_rsp_neg;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: vector table, corner sequences, random commands vs a reference model.
module tb_alu_cmd_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_cmd_sequencer_if #(.WIDTH(8), .REP_W(4)) bus ();
  alu_cmd_sequencer #(.WIDTH(8), .REP_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] q_in1[$];
  logic [7:0] m_acc;

  function automatic logic [7:0] alu_f(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
    case (s)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return ~(a ^ b);
      3'd4: return a + b;
      3'd5: return a - b;
      3'd6: return a << b[2:0];
      default: return a >> b[2:0];
    endcase
  endfunction

  // External combinational ALU.
  assign bus.alu_out = alu_f(bus.alu_sel, bus.alu_in1, bus.alu_in2);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] s, input logic src, input logic [7:0] a,
                      input logic [7:0] b, input logic [3:0] rep);
    bus.cmd_sel   = s;
    bus.cmd_src   = src;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_rep   = rep;
    bus.cmd_valid = 1'b1;
    check("cmd_ready_before_accept", bus.cmd_ready, 1);
    step();
    bus.cmd_valid = 1'b0;
  endtask

  // Waits for rsp_valid (bounded), recording operand 1 presented on each ISSUE cycle.
  task automatic wait_rsp(output int k);
    k = 0;
    q_in1.delete();
    q_in1.push_back(bus.alu_in1);
    while (!bus.rsp_valid && k < 40) begin
      step();
      k++;
      if (!bus.rsp_valid) q_in1.push_back(bus.alu_in1);
    end
  endtask

  task automatic check_flags(input logic [7:0] exp);
`ifdef STATUS_FLAGS_EN
    check("rsp_zero", bus.rsp_zero, (exp == 8'h00));
    check("rsp_neg", bus.rsp_neg, exp[7]);
`else
    check("rsp_data_flags_src", bus.rsp_data, exp);
`endif
  endtask

  // Iterated operation from the command rules: op1, then rep+1 applications of op(x, b).
  function automatic logic [7:0] ref_result(input logic [2:0] s, input logic [7:0] op1,
                                            input logic [7:0] b, input int rep);
    logic [7:0] x;
    x = op1;
    for (int i = 0; i <= rep; i++) x = alu_f(s, x, b);
    return x;
  endfunction

  typedef struct {
    logic [2:0] sel;
    logic       src;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] rep;
    logic [7:0] exp_in1;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int k;
    int seen;
    logic chain_ok;

    vecs[0]  = '{3'd4, 1'b0, 8'h05, 8'h03, 4'd0,  8'h05, 8'h08};
    vecs[1]  = '{3'd4, 1'b1, 8'h00, 8'h02, 4'd0,  8'h08, 8'h0A};
    vecs[2]  = '{3'd7, 1'b1, 8'h00, 8'h01, 4'd0,  8'h0A, 8'h05};
    vecs[3]  = '{3'd6, 1'b0, 8'h01, 8'h01, 4'd3,  8'h01, 8'h10};
    vecs[4]  = '{3'd5, 1'b0, 8'h00, 8'h01, 4'd0,  8'h00, 8'hFF};
    vecs[5]  = '{3'd2, 1'b0, 8'hA5, 8'hA5, 4'd0,  8'hA5, 8'h00};
    vecs[6]  = '{3'd1, 1'b1, 8'h77, 8'h3C, 4'd0,  8'h00, 8'h3C};
    vecs[7]  = '{3'd3, 1'b0, 8'h0F, 8'hF0, 4'd1,  8'h0F, 8'h0F};
    vecs[8]  = '{3'd0, 1'b0, 8'hFF, 8'h0F, 4'd15, 8'hFF, 8'h0F};
    vecs[9]  = '{3'd4, 1'b0, 8'hFF, 8'h01, 4'd0,  8'hFF, 8'h00};
    vecs[10] = '{3'd5, 1'b1, 8'h00, 8'h01, 4'd15, 8'h00, 8'hF0};
    vecs[11] = '{3'd4, 1'b1, 8'h00, 8'h80, 4'd1,  8'hF0, 8'hF0};

    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_sel = '0; bus.cmd_src = 1'b0; bus.cmd_a = '0; bus.cmd_b = '0; bus.cmd_rep = '0;
    bus.rsp_ready = 1'b0;
    step();
    step();
    check("rst_cmd_ready", bus.cmd_ready, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_acc", bus.acc, 0);
    check("rst_alu_in1", bus.alu_in1, 0);
    check("rst_alu_sel", bus.alu_sel, 0);
    check("rst_rsp_data", bus.rsp_data, 0);
    rst = 1'b0;
    #1;
    check("idle_cmd_ready", bus.cmd_ready, 1);

    // Table vectors; rsp_ready held high ahead of rsp_valid throughout.
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      send(vecs[i].sel, vecs[i].src, vecs[i].a, vecs[i].b, vecs[i].rep);
      wait_rsp(k);
      check($sformatf("vec%0d_latency", i), k, vecs[i].rep + 1);
      check($sformatf("vec%0d_rsp_data", i), bus.rsp_data, vecs[i].exp_data);
      check($sformatf("vec%0d_acc", i), bus.acc, vecs[i].exp_data);
      check($sformatf("vec%0d_in1_first", i), q_in1[0], vecs[i].exp_in1);
      check($sformatf("vec%0d_evals", i), q_in1.size(), vecs[i].rep + 1);
      chain_ok = 1'b1;
      for (int j = 0; j + 1 < q_in1.size(); j++)
        if (q_in1[j+1] !== alu_f(vecs[i].sel, q_in1[j], vecs[i].b)) chain_ok = 1'b0;
      check($sformatf("vec%0d_in1_chain", i), chain_ok, 1);
      check_flags(vecs[i].exp_data);
      step();
      check($sformatf("vec%0d_cmd_ready_after", i), bus.cmd_ready, 1);
      check($sformatf("vec%0d_rsp_valid_after", i), bus.rsp_valid, 0);
    end

    // Backpressure: response held three cycles, a command pulse in the window is ignored.
    bus.rsp_ready = 1'b0;
    send(3'd4, 1'b0, 8'h10, 8'h20, 4'd0);
    wait_rsp(k);
    check("bp_latency", k, 1);
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        bus.cmd_sel = 3'd2; bus.cmd_src = 1'b0; bus.cmd_a = 8'hFF; bus.cmd_b = 8'h00;
        bus.cmd_rep = 4'd0; bus.cmd_valid = 1'b1;
      end
      step();
      bus.cmd_valid = 1'b0;
      check("bp_rsp_valid", bus.rsp_valid, 1);
      check("bp_rsp_data", bus.rsp_data, 8'h30);
      check("bp_cmd_ready", bus.cmd_ready, 0);
      check("bp_busy", bus.busy, 1);
    end
    bus.rsp_ready = 1'b1;
    step();
    check("bp_released_busy", bus.busy, 0);
    step();
    check("bp_pulse_ignored_busy", bus.busy, 0);
    check("bp_pulse_ignored_in1", bus.alu_in1, 8'h10);
    check("bp_pulse_ignored_sel", bus.alu_sel, 3'd4);
    check("bp_acc", bus.acc, 8'h30);

    // Reset in the middle of a rep=5 ISSUE phase.
    send(3'd4, 1'b0, 8'h01, 8'h01, 4'd5);
    step();
    step();
    check("mid_busy_before_rst", bus.busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_rsp_valid", bus.rsp_valid, 0);
    check("mid_rst_acc", bus.acc, 0);
    check("mid_rst_alu_in1", bus.alu_in1, 0);
    check("mid_rst_alu_in2", bus.alu_in2, 0);
    check("mid_rst_alu_sel", bus.alu_sel, 0);
    check("mid_rst_cmd_ready", bus.cmd_ready, 1);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.rsp_valid) seen++;
    end
    check("mid_rst_no_response", seen, 0);

    // Random commands against the reference model.
    m_acc = 8'h00;
    for (int n = 0; n < 40; n++) begin
      logic [2:0] s;
      logic       src;
      logic [7:0] a, b, op1, exp;
      logic [3:0] rep;
      int         d;
      s   = 3'($urandom_range(0, 7));
      src = 1'($urandom_range(0, 1));
      a   = 8'($urandom);
      b   = 8'($urandom);
      rep = 4'($urandom_range(0, 15));
      op1 = src ? m_acc : a;
      exp = ref_result(s, op1, b, int'(rep));
      bus.rsp_ready = 1'($urandom_range(0, 1));
      send(s, src, a, b, rep);
      wait_rsp(k);
      bus.rsp_ready = 1'b0;
      check($sformatf("rnd%0d_latency", n), k, int'(rep) + 1);
      check($sformatf("rnd%0d_rsp_data", n), bus.rsp_data, exp);
      check($sformatf("rnd%0d_acc", n), bus.acc, exp);
      check_flags(exp);
      m_acc = exp;
      d = $urandom_range(0, 2);
      for (int i = 0; i < d; i++) begin
        step();
        check($sformatf("rnd%0d_hold", n), bus.rsp_data, exp);
      end
      bus.rsp_ready = 1'b1;
      step();
      check($sformatf("rnd%0d_idle", n), bus.cmd_ready, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Initiator side of the 8-bit ALU operand/select interface.
- Accepts operation commands over a valid/ready handshake and drives registered in1/in2/sel to an external combinational ALU.
- Iterates the operation with the result fed back as operand 1 when a repeat is requested. Returns the final result over a valid/ready response handshake.
- Holds an accumulator so that chained commands can reuse the previous result.

Parameters:
- WIDTH, 8, data width of operands, result and accumulator.
- REP_W, 4, width of the repeat-count field.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept a command.
- cmd_sel  input  3  ALU op: 000 AND, 001 OR, 010 XOR, 011 XNOR, 100 ADD, 101 SUB, 110 SLL, 111 SRL.
- cmd_src  input  1  operand 1 source: 0 = cmd_a, 1 = accumulator.
- cmd_a  input  WIDTH  operand 1 (used when cmd_src=0).
- cmd_b  input  WIDTH  operand 2. For shifts, only bits [2:0] are used by the ALU.
- cmd_rep  input  REP_W  extra iterations. Total ALU evaluations = cmd_rep+1.
- alu_in1  output  WIDTH  to ALU in1.
- alu_in2  output  WIDTH  to ALU in2.
- alu_sel  output  3  to ALU sel.
- alu_out  input  WIDTH  from ALU out1 (combinational function of alu_in1/alu_in2/alu_sel).
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer takes result.
- rsp_data  output  WIDTH  final result.
- busy  output  1  state != IDLE.
- acc  output  WIDTH  accumulator (last delivered result).

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high. All state updates on the rising edge.
- Reset values, applied on any edge with rst=1 regardless of state:
  - state = IDLE.
  - alu_in1, alu_in2, rsp_data, acc = 0.
  - alu_sel = 000, rep counter = 0.
  - rsp_valid = 0, busy = 0.
- cmd_ready: combinational, equal to (state==IDLE && !rst). A command is accepted on an edge where cmd_valid && cmd_ready.
- States:
  - IDLE → ISSUE on accept. Loads:
    - alu_in1 = cmd_src ? acc : cmd_a
    - alu_in2 = cmd_b
    - alu_sel = cmd_sel
    - counter = cmd_rep
  - ISSUE: each cycle, the ALU evaluates the registered operands.
    - If counter != 0: alu_in1 <= alu_out, counter <= counter-1, stay in ISSUE. alu_in2 and alu_sel are held.
    - If counter == 0: rsp_data <= alu_out, acc <= alu_out, rsp_valid <= 1, go to RESP.
  - RESP: rsp_valid=1. rsp_data is stable until the handshake.
    - On rsp_ready=1: rsp_valid <= 0 and return to IDLE.
    - A new command cannot be accepted in the same cycle (cmd_ready=0 in RESP).
- Latency: accept edge at T. rsp_valid rises at edge T+cmd_rep+1. Minimum command-to-command spacing is cmd_rep+3 cycles with rsp_ready held at 1.
- Arithmetic: all results truncate to WIDTH. ADD/SUB wrap modulo 2^WIDTH. Shift amount = alu_in2[2:0]. No carry or borrow is retained.
- Accumulator: updated only at the ISSUE→RESP transition. Commands with cmd_src=1 read the value present at the accept edge.
- Boundaries:
  - cmd_rep = max (15) gives 16 evaluations. The counter does not wrap.
  - cmd_valid while busy is ignored; the initiator holds it.
  - rsp_ready asserted before rsp_valid has no effect.
  - Reset mid-ISSUE or mid-RESP discards the in-flight result and clears acc.
- alu_* outputs hold their last values in IDLE/RESP; they are not cleared except by reset.

Optional Feature:
- Macro: STATUS_FLAGS_EN.
- Defined: adds two outputs, registered alongside rsp_data and cleared on reset.
  - rsp_zero (1): rsp_data == 0.
  - rsp_neg (1): rsp_data[WIDTH-1].
- Undefined: these ports do not exist and there is no associated logic.

Test Plan:
- Reset then ADD, cmd_src=0, a=0x05, b=0x03, rep=0, rsp_ready=1 → rsp_valid one edge after accept, rsp_data=0x08, acc=0x08, cmd_ready back to 1 the cycle after the handshake.
- SLL, a=0x01, b=0x01, rep=3 → four evaluations, rsp_data=0x10, rsp_valid at accept+4; alu_in1 sequence 0x01,0x02,0x04,0x08.
- SUB, a=0x00, b=0x01, rep=0 → rsp_data=0xFF (wrap); with STATUS_FLAGS_EN, rsp_neg=1, rsp_zero=0. XOR, a=0xA5, b=0xA5 → 0x00, rsp_zero=1.
- Chaining: ADD 0x05+0x03, then ADD cmd_src=1, b=0x02 → 0x0A; then SRL cmd_src=1, b=0x01 → 0x05.
- Backpressure: hold rsp_ready=0 for 3 cycles after rsp_valid → rsp_data constant, cmd_ready=0, busy=1; a cmd_valid pulse during this window is not accepted.
- Reset asserted in ISSUE with rep=5 → next cycle state IDLE, rsp_valid=0, acc=0x00, alu_* =0, no response delivered.
